egress_tx_framer: RTL
=====================

# egress_tx_framer

Single-clock egress framer between a per-port egress frame FIFO and the Ethernet MAC transmit side. It pops complete frames from the FIFO, length first and then data words, and replays them onto an EthernetTxBus with correct start, byte-count and inter-frame-gap sequencing. It is the transmit-direction counterpart of the ingress path. While the link is down it flushes frames instead of transmitting them, so the FIFO never wedges.

## Interface
Parameters:
- IFG_CYCLES, 3: minimum idle tx_clk cycles between the last data word of one frame and the next tx_bus.start.
- LEN_WIDTH, 11: width of the frame byte length field (maximum 2047 bytes).

Ports:
- tx_clk  in  1  transmit clock; all logic is on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active low.
- link_up  in  1  PHY link status, synchronous to tx_clk.
- fifo_frame_ready  in  1  at least one complete frame is present in the FIFO.
- fifo_frame_bytelen  in  LEN_WIDTH  byte length of the head frame; valid while fifo_frame_ready is high.
- fifo_frame_pop  out  1  one-cycle pulse that consumes the head length entry.
- fifo_rd_en  out  1  reads one 32-bit data word.
- fifo_rd_data  in  32  data word; valid the cycle after fifo_rd_en.
- tx_ready  in  1  MAC is idle and will accept a start. After a start the MAC consumes one word per cycle with no backpressure.
- tx_bus  out  EthernetTxBus  fields: start, data_valid, bytes_valid[2:0], data[31:0].
- frames_sent  out  16  count of frames transmitted; wraps.
- frames_dropped  out  16  count of frames flushed or zero-length; wraps.

## Operation
- States:
  - IDLE: waits for a frame.
  - SEND: reads words and drives tx_bus.
  - FLUSH: reads words and discards them.
  - GAP: counts the inter-frame gap.
- IDLE exits when fifo_frame_ready=1 and the gap has been met. In that cycle the block latches the length, pulses fifo_frame_pop and computes words = ceil(len/4).
  - len=0: no data read, no tx activity. frames_dropped++. Stay in IDLE.
  - link_up=0: go to FLUSH.
  - link_up=1 and tx_ready=1: assert fifo_rd_en for the first word and go to SEND.
  - link_up=1 and tx_ready=0: stay in IDLE without popping.
- SEND:
  - fifo_rd_en is asserted on consecutive cycles until all words are read.
  - Each returned word is registered onto tx_bus with data_valid=1.
  - bytes_valid=4 on every word except the last, where bytes_valid = len mod 4, with 0 mapping to 4.
  - data[31:24] is the first byte on the wire. Unused low bytes of the last word are forced to 0.
- Link drop during SEND: the remaining words are still read so the FIFO stays aligned, but data_valid is suppressed from the next output cycle onward. The frame counts as dropped, not sent. The MAC sees a truncated frame with no commit.
- FLUSH: reads all words with tx_bus held idle. frames_dropped++ on the last read.
- After the last word of SEND or FLUSH, the block goes to GAP for IFG_CYCLES cycles and then returns to IDLE. frames_sent++ on the last output word of a frame that completed with link_up high throughout.

## Timing
- Reset values: all tx_bus fields 0, fifo_frame_pop=0, fifo_rd_en=0, both counters 0, state IDLE, gap satisfied.
- Cycle N is the IDLE decision cycle: fifo_frame_pop=1 and fifo_rd_en=1 (first word).
- Cycle N+1: tx_bus.start=1.
- Cycles N+2 … N+1+words: data_valid=1 with no bubbles.
- fifo_rd_en is high during cycles N … N+words-1.
- The earliest next start is cycle N+2+words+IFG_CYCLES.
- fifo_frame_ready is ignored outside IDLE.
- tx_ready is sampled only in IDLE.
- Reset asserted mid-frame: all outputs clear immediately. FIFO realignment after reset is the FIFO owner's responsibility, since both blocks share the reset.
- Counter wrap: 16'hFFFF increments to 0.

## Structure
- EthernetTxBus comes from the shared Ethernet bus package, the same package that holds EthernetRxBus.
- The state enum and the word-count arithmetic are local to this module: words = (len+3)>>2 in LEN_WIDTH-1 bits, last-word bytes from len[1:0].
- No sub-module; the gap counter and the word counter are inline.

## Test plan
- 19-byte frame with words feedface, deadbeef, cafef00d, baadc0de, 41414100; link up, tx_ready=1 -> start at N+1; five data_valid beats with bytes_valid 4,4,4,4,3; last data 32'h41414100; frames_sent=1.
- Two 32-byte frames queued back-to-back, IFG_CYCLES=3 -> second start exactly 3 idle cycles after the first frame's last beat; each frame has 8 beats with bytes_valid=4.
- link_up=0 with a 12-byte frame queued -> pop plus 3 fifo_rd_en pulses, tx_bus stays 0, frames_dropped=1, next frame is sent correctly after link_up returns.
- link_up falls after the second beat of a 32-byte frame -> fifo_rd_en still totals 8; data_valid stops at the beat following the drop; frames_dropped=1, frames_sent=0.
- Head frame with len=0 -> single pop, no rd_en, no start; frames_dropped=1; a following 4-byte frame gives one beat with bytes_valid=4.
- rst_n pulsed low in the middle of SEND -> all outputs 0 in the same cycle; counters 0; IDLE after release.

Source files
------------

// File: rtl/eth_bus_pkg.sv
// Shared Ethernet MAC-side bus bundles.
// Word-wide Tx/Rx buses for the egress and ingress paths.
package eth_bus_pkg;

  localparam int ETH_WORD_BYTES = 4;

  typedef struct packed {
    logic        start;
    logic        data_valid;
    logic [2:0]  bytes_valid;
    logic [31:0] data;
  } EthernetTxBus;

  typedef struct packed {
    logic        start;
    logic        data_valid;
    logic [2:0]  bytes_valid;
    logic [31:0] data;
    logic        commit;
    logic        abort;
  } EthernetRxBus;

endpackage

// File: rtl/egress_tx_framer.sv
// Egress framer: replays FIFO frames onto the MAC Tx bus.
// Flushes frames while the link is down so the FIFO drains.
module egress_tx_framer
  import eth_bus_pkg::*;
#(
  parameter int IFG_CYCLES = 3,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                 tx_clk,
  input  logic                 rst_n,
  input  logic                 link_up,
  input  logic                 fifo_frame_ready,
  input  logic [LEN_WIDTH-1:0] fifo_frame_bytelen,
  output logic                 fifo_frame_pop,
  output logic                 fifo_rd_en,
  input  logic [31:0]          fifo_rd_data,
  input  logic                 tx_ready,
  output EthernetTxBus         tx_bus,
  output logic [15:0]          frames_sent,
  output logic [15:0]          frames_dropped
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_FLUSH,
    S_GAP
  } state_t;

  localparam int WW = LEN_WIDTH - 1;
  localparam int GW =
    (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam int GAP_LOAD =
    (IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0;

  state_t         state_q, state_d;
  logic [WW-1:0]  cnt_q, cnt_d;
  logic [1:0]     len_lo_q, len_lo_d;
  logic           ok_q, ok_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic [15:0]    sent_q, sent_d;
  logic [15:0]    drop_q, drop_d;
  EthernetTxBus   bus_q, bus_d;
  logic [WW-1:0]  words;

  function automatic logic [2:0] last_bytes(
    input logic [1:0] lo
  );
    return (lo == 2'd0) ? 3'd4 : {1'b0, lo};
  endfunction

  function automatic logic [31:0] keep_bytes(
    input logic [31:0] d,
    input logic [1:0]  lo
  );
    logic [31:0] r;
    case (lo)
      2'd1:    r = {d[31:24], 24'h0};
      2'd2:    r = {d[31:16], 16'h0};
      2'd3:    r = {d[31:8], 8'h0};
      default: r = d;
    endcase
    return r;
  endfunction

  assign words = WW'(
    ({1'b0, fifo_frame_bytelen}
      + (LEN_WIDTH + 1)'(3)) >> 2);

  // Next-state, FIFO strobes and next Tx bus word
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    len_lo_d       = len_lo_q;
    ok_d           = ok_q;
    gap_d          = gap_q;
    sent_d         = sent_q;
    drop_d         = drop_q;
    bus_d          = '0;
    fifo_frame_pop = 1'b0;
    fifo_rd_en     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (fifo_frame_ready) begin
          if (fifo_frame_bytelen == '0) begin
            fifo_frame_pop = 1'b1;
            drop_d         = drop_q + 16'd1;
          end else if (!link_up) begin
            fifo_frame_pop = 1'b1;
            cnt_d          = words;
            state_d        = S_FLUSH;
          end else if (tx_ready) begin
            fifo_frame_pop = 1'b1;
            fifo_rd_en     = 1'b1;
            cnt_d          = words - WW'(1);
            len_lo_d       = fifo_frame_bytelen[1:0];
            ok_d           = 1'b1;
            bus_d.start    = 1'b1;
            state_d        = S_SEND;
          end
        end
      end
      S_SEND: begin
        fifo_rd_en = (cnt_q != '0);
        if (ok_q && link_up) begin
          bus_d.data_valid = 1'b1;
          if (cnt_q == '0) begin
            bus_d.bytes_valid = last_bytes(len_lo_q);
            bus_d.data =
              keep_bytes(fifo_rd_data, len_lo_q);
          end else begin
            bus_d.bytes_valid = 3'd4;
            bus_d.data        = fifo_rd_data;
          end
        end else begin
          ok_d = 1'b0;
        end
        if (cnt_q == '0) begin
          if (ok_q && link_up) begin
            sent_d = sent_q + 16'd1;
          end else begin
            drop_d = drop_q + 16'd1;
          end
          gap_d   = GW'(GAP_LOAD);
          state_d = (IFG_CYCLES > 0) ? S_GAP : S_IDLE;
        end else begin
          cnt_d = cnt_q - WW'(1);
        end
      end
      S_FLUSH: begin
        fifo_rd_en = 1'b1;
        cnt_d      = cnt_q - WW'(1);
        if (cnt_q == WW'(1)) begin
          drop_d  = drop_q + 16'd1;
          gap_d   = GW'(GAP_LOAD);
          state_d = (IFG_CYCLES > 0) ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!rst_n) begin
      fifo_frame_pop = 1'b0;
      fifo_rd_en     = 1'b0;
    end
  end

  // State, counters and registered Tx bus
  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      len_lo_q <= '0;
      ok_q     <= 1'b0;
      gap_q    <= '0;
      sent_q   <= '0;
      drop_q   <= '0;
      bus_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_lo_q <= len_lo_d;
      ok_q     <= ok_d;
      gap_q    <= gap_d;
      sent_q   <= sent_d;
      drop_q   <= drop_d;
      bus_q    <= bus_d;
    end
  end

  assign tx_bus         = bus_q;
  assign frames_sent    = sent_q;
  assign frames_dropped = drop_q;

endmodule
